// File: rtl/bios_loader.sv
// Streams a BIOS image from the hps_io ioctl download port into the Next186 BIOS load port.
// Optional build macro: BIOS_LOADER_CKSUM_EN enables the running word checksum on cksum.
module bios_loader #(
   parameter logic [7:0] INDEX     = 8'd0,
   parameter int         FIFO_AW   = 5,
   parameter int         MAX_WORDS = 8192
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [12:0] bios_addr,
   output logic [15:0] bios_din,
   output logic        bios_wr,
   input  logic        bios_req,
   output logic        bios_loaded,
   output logic        bios_overflow,
   output logic [15:0] cksum
);

   localparam int                 DEPTH        = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   DEPTH_C      = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   WAIT_MARK_C  = (FIFO_AW+1)'(DEPTH - 1);
   localparam logic [FIFO_AW:0]   CNT_ONE_C    = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW:0]   CNT_ZERO_C   = (FIFO_AW+1)'(0);
   localparam logic [FIFO_AW-1:0] PTR_ONE_C    = FIFO_AW'(1);
   localparam logic [FIFO_AW-1:0] PTR_ZERO_C   = FIFO_AW'(0);
   localparam logic [24:0]        BYTE_LIMIT_C = 25'(MAX_WORDS * 2);
   localparam logic [12:0]        ADDR_MAX_C   = 13'h1FFF;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

   state_t             state_r;
   logic [15:0]        fifo_mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r;
   logic [FIFO_AW-1:0] rd_ptr_r;
   logic [FIFO_AW:0]   count_r;
   logic               dl_d_r;
   logic [7:0]         low_r;
   logic               low_valid_r;
   logic               push_pend_r;
   logic [15:0]        push_data_r;
   logic               wait_r;
   logic [12:0]        bios_addr_r;
   logic [15:0]        bios_din_r;
   logic               bios_wr_r;
   logic               loaded_r;
   logic               ovf_r;

   logic               start_s;
   logic               pop_s;
   logic               push_s;
   logic [FIFO_AW:0]   count_next_s;
   logic [FIFO_AW-1:0] rd_next_s;
   logic [15:0]        head_next_s;

   // Session start, FIFO handshake and the head word the FIFO will present next cycle.
   always_comb begin
      start_s      = 1'b0;
      pop_s        = 1'b0;
      push_s       = 1'b0;
      count_next_s = count_r;
      rd_next_s    = rd_ptr_r;
      head_next_s  = 16'h0000;
      if (ioctl_download && !dl_d_r && (ioctl_index == INDEX) &&
          ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
         start_s = 1'b1;
      end else begin
         start_s = 1'b0;
      end
      pop_s  = bios_req && bios_wr_r && (count_r != CNT_ZERO_C);
      push_s = push_pend_r && bios_wr_r && ((count_r != DEPTH_C) || pop_s);
      if (push_s && !pop_s) begin
         count_next_s = count_r + CNT_ONE_C;
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - CNT_ONE_C;
      end else begin
         count_next_s = count_r;
      end
      if (pop_s) begin
         rd_next_s = rd_ptr_r + PTR_ONE_C;
      end else begin
         rd_next_s = rd_ptr_r;
      end
      // A word written this cycle into the slot about to become head bypasses the array.
      if (push_s && (wr_ptr_r == rd_next_s)) begin
         head_next_s = push_data_r;
      end else begin
         head_next_s = fifo_mem_r[rd_next_s];
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk_sys) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= push_data_r;
      end
   end

   // Session state machine, byte packing, FIFO pointers and registered outputs.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         wr_ptr_r    <= PTR_ZERO_C;
         rd_ptr_r    <= PTR_ZERO_C;
         count_r     <= CNT_ZERO_C;
         dl_d_r      <= 1'b0;
         low_r       <= 8'h00;
         low_valid_r <= 1'b0;
         push_pend_r <= 1'b0;
         push_data_r <= 16'h0000;
         wait_r      <= 1'b0;
         bios_addr_r <= 13'd0;
         bios_din_r  <= 16'h0000;
         bios_wr_r   <= 1'b0;
         loaded_r    <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         dl_d_r <= ioctl_download;
         if (bios_wr_r) begin
            push_pend_r <= 1'b0;
            count_r     <= count_next_s;
            rd_ptr_r    <= rd_next_s;
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (count_next_s != CNT_ZERO_C) begin
               bios_din_r <= head_next_s;
            end
            // Address saturates so it can only wrap through a new session.
            if (pop_s && (bios_addr_r != ADDR_MAX_C)) begin
               bios_addr_r <= bios_addr_r + 13'd1;
            end
            if ((bios_req && !pop_s) || (push_pend_r && !push_s)) begin
               ovf_r <= 1'b1;
            end
         end
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start_s) begin
                  state_r     <= ST_LOAD;
                  bios_wr_r   <= 1'b1;
                  loaded_r    <= 1'b0;
                  ovf_r       <= 1'b0;
                  bios_addr_r <= 13'd0;
                  count_r     <= CNT_ZERO_C;
                  wr_ptr_r    <= PTR_ZERO_C;
                  rd_ptr_r    <= PTR_ZERO_C;
                  push_pend_r <= 1'b0;
                  low_valid_r <= 1'b0;
                  wait_r      <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (ioctl_download) begin
                  wait_r <= (count_next_s >= WAIT_MARK_C);
                  if (ioctl_wr) begin
                     if (ioctl_addr >= BYTE_LIMIT_C) begin
                        ovf_r <= 1'b1;
                     end else if (ioctl_addr[0]) begin
                        push_pend_r <= 1'b1;
                        push_data_r <= {ioctl_dout, low_r};
                        low_valid_r <= 1'b0;
                     end else begin
                        low_r       <= ioctl_dout;
                        low_valid_r <= 1'b1;
                     end
                  end
               end else begin
                  // Flush an unpaired trailing byte as a zero-extended word.
                  state_r     <= ST_DRAIN;
                  wait_r      <= 1'b0;
                  push_pend_r <= low_valid_r;
                  push_data_r <= {8'h00, low_r};
                  low_valid_r <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (count_next_s == CNT_ZERO_C) begin
                  state_r   <= ST_DONE;
                  bios_wr_r <= 1'b0;
                  loaded_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BIOS_LOADER_CKSUM_EN
   logic [15:0] cksum_r;

   // Sum of every word the system has consumed in the current session.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cksum_r <= 16'h0000;
      end else if (start_s) begin
         cksum_r <= 16'h0000;
      end else if (pop_s) begin
         cksum_r <= cksum_r + bios_din_r;
      end else begin
         cksum_r <= cksum_r;
      end
   end

   assign cksum = cksum_r;
`else
   assign cksum = 16'h0000;
`endif

   assign ioctl_wait    = wait_r;
   assign bios_addr     = bios_addr_r;
   assign bios_din      = bios_din_r;
   assign bios_wr       = bios_wr_r;
   assign bios_loaded   = loaded_r;
   assign bios_overflow = ovf_r;

endmodule
